utilization_accum: RTL

//  Consumes the conv-array activity strobes that feed the utilization monitor interface
//  (dataflow_en, conv_vld, loader/weight requests, layer_start/done, sim_done).

---
 rtl/util_pkg.sv | 25 ++
 rtl/util_div.sv | 70 +++++++
 rtl/utilization_accum.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/util_pkg.sv
// Shared types and constants for the conv-array utilization accumulator.
package util_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned PM_SCALE = 1000;
    localparam int unsigned PM_W     = 10;
    localparam int unsigned QUOT_W   = 11;

    // Report record at the default widths (CNT_W=32, LAYER_W=8).
    typedef struct packed {
        logic [7:0]  layer;
        logic [31:0] cycles;
        logic [31:0] active;
        logic [31:0] mac;
        logic [31:0] stall;
        logic [9:0]  util_pm;
        logic [1:0]  flags;
    } layer_rpt_t;

endpackage

// File: rtl/util_div.sv
// Restoring divider: one load cycle, then one quotient bit per cycle for QUOT_W cycles.
module util_div #(
    parameter int unsigned NUM_W  = 42,
    parameter int unsigned DEN_W  = 36,
    parameter int unsigned QUOT_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_W-1:0]  num,
    input  logic [DEN_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [QUOT_W-1:0] quot
);

    localparam int unsigned ITER_W = $clog2(QUOT_W);

    logic              busy_q;
    logic [ITER_W-1:0] iter_q;
    logic [DEN_W-1:0]  rem_q;
    logic [DEN_W-1:0]  den_q;
    logic [QUOT_W-1:0] low_q;
    logic [QUOT_W-2:0] qacc_q;
    logic [QUOT_W-1:0] quot_q;

    logic [DEN_W:0]    trial;
    logic              ge;
    logic [DEN_W-1:0]  rem_nx;

    always_comb begin
        trial  = {rem_q, low_q[QUOT_W-1]};
        ge     = (trial >= {1'b0, den_q});
        rem_nx = DEN_W'(ge ? trial - {1'b0, den_q} : trial);
        done   = busy_q && (iter_q == ITER_W'(QUOT_W - 1));
    end

    // The quotient never exceeds QUOT_W bits, so the high part of num is already below den.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            low_q  <= '0;
            qacc_q <= '0;
            quot_q <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            iter_q <= '0;
            rem_q  <= DEN_W'(num >> QUOT_W);
            den_q  <= den;
            low_q  <= num[QUOT_W-1:0];
            qacc_q <= '0;
        end else if (busy_q) begin
            rem_q  <= rem_nx;
            low_q  <= low_q << 1;
            iter_q <= iter_q + ITER_W'(1);
            qacc_q <= {qacc_q[QUOT_W-3:0], ge};
            if (done) begin
                busy_q <= 1'b0;
                quot_q <= {qacc_q, ge};
            end
        end
    end

    assign busy = busy_q;
    assign quot = quot_q;

endmodule

// File: rtl/utilization_accum.sv
// Per-layer activity counters for the conv array, with a permille utilization report
// delivered over valid/ready.
module utilization_accum
    import util_pkg::*;
#(
    parameter int unsigned NUM_PE  = 9,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned LAYER_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dataflow_en,
    input  logic [NUM_PE-1:0]  conv_vld,
    input  logic               weight_req_row,
    input  logic               weight_req_frame,
    input  logic               input_loader_req,
    input  logic               layer_start,
    input  logic               layer_done,
    input  logic               sim_done,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [LAYER_W-1:0] rpt_layer,
    output logic [CNT_W-1:0]   rpt_cycles,
    output logic [CNT_W-1:0]   rpt_active,
    output logic [CNT_W-1:0]   rpt_mac,
    output logic [CNT_W-1:0]   rpt_stall,
    output logic [PM_W-1:0]    rpt_util_pm,
    output logic [1:0]         rpt_flags,
    output logic               err_protocol,
    output logic               err_overflow,
    output logic               sim_finished
);

    localparam int unsigned PC_W  = $clog2(NUM_PE + 1);
    localparam int unsigned NUM_W = CNT_W + 10;
    localparam int unsigned DEN_W = CNT_W + 4;

    // Returns {saturated, sum}; the sum sticks at all-ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[CNT_W]) begin
            return {1'b1, {CNT_W{1'b1}}};
        end
        return s;
    endfunction

    state_e state_q, state_d;

    logic [CNT_W-1:0]   cyc_q, act_q, mac_q, stl_q;
    logic               sat_q;
    logic [LAYER_W-1:0] layer_q;

    logic [LAYER_W-1:0] rpt_layer_q;
    logic [CNT_W-1:0]   rpt_cycles_q, rpt_active_q, rpt_mac_q, rpt_stall_q;
    logic [1:0]         rpt_flags_q;
    logic               rpt_valid_q, rpt_valid_d;
    logic               err_prot_q, err_ovf_q;

    logic               in_run, counting, closing, trunc, pending, accept;
    logic [PC_W-1:0]    vld_cnt;
    logic [CNT_W-1:0]   cyc_b, act_b, mac_b, stl_b;
    logic [CNT_W:0]     cyc_s, act_s, mac_s, stl_s;
    logic               sat_n;
    logic [NUM_W-1:0]   mac_ext, div_num;
    logic [DEN_W-1:0]   div_den;
    logic               div_busy, div_done;
    logic [QUOT_W-1:0]  div_quot;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sim_done) begin
                    state_d = DONE;
                end else if (layer_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sim_done) begin
                    state_d = DONE;
                end else if (layer_done && !layer_start) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_run       = (state_q == RUN);
        counting     = in_run || ((state_q == IDLE) && layer_start && !sim_done);
        closing      = in_run && (layer_done || sim_done);
        trunc        = in_run && sim_done;
        sim_finished = (state_q == DONE) && !div_busy && !rpt_valid_q;
    end

    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            vld_cnt = vld_cnt + PC_W'(conv_vld[i]);
        end
    end

    // A layer opened from IDLE counts its start cycle from zero.
    always_comb begin
        cyc_b = in_run ? cyc_q : '0;
        act_b = in_run ? act_q : '0;
        mac_b = in_run ? mac_q : '0;
        stl_b = in_run ? stl_q : '0;
        cyc_s = sat_add(cyc_b, CNT_W'(1));
        act_s = sat_add(act_b, CNT_W'(dataflow_en));
        mac_s = sat_add(mac_b, dataflow_en ? CNT_W'(vld_cnt) : '0);
        stl_s = sat_add(stl_b, CNT_W'(!dataflow_en &&
                        (weight_req_row || weight_req_frame || input_loader_req)));
        sat_n = (in_run && sat_q) | cyc_s[CNT_W] | act_s[CNT_W] | mac_s[CNT_W] | stl_s[CNT_W];
    end

    always_ff @(posedge clk) begin
        if (rst || !counting || closing) begin
            cyc_q <= '0;
            act_q <= '0;
            mac_q <= '0;
            stl_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cyc_q <= cyc_s[CNT_W-1:0];
            act_q <= act_s[CNT_W-1:0];
            mac_q <= mac_s[CNT_W-1:0];
            stl_q <= stl_s[CNT_W-1:0];
            sat_q <= sat_n;
        end
    end

    // mac*1000 as shifts; denominator is the PE-slot count of the layer.
    always_comb begin
        mac_ext = NUM_W'(mac_s[CNT_W-1:0]);
        div_num = (mac_ext << 10) - (mac_ext << 4) - (mac_ext << 3);
        div_den = DEN_W'(cyc_s[CNT_W-1:0]) * DEN_W'(NUM_PE);
    end

    assign pending = rpt_valid_q && !rpt_ready;
    assign accept  = closing && !div_busy && !pending;

    util_div #(
        .NUM_W  (NUM_W),
        .DEN_W  (DEN_W),
        .QUOT_W (QUOT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .num   (div_num),
        .den   (div_den),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_comb begin
        rpt_valid_d = rpt_valid_q;
        if (div_done) begin
            rpt_valid_d = 1'b1;
        end else if (rpt_valid_q && rpt_ready) begin
            rpt_valid_d = 1'b0;
        end
    end

    // Snapshot only on an accepted close, so fields stay put while the divide runs
    // and while the report waits for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_q      <= '0;
            rpt_layer_q  <= '0;
            rpt_cycles_q <= '0;
            rpt_active_q <= '0;
            rpt_mac_q    <= '0;
            rpt_stall_q  <= '0;
            rpt_flags_q  <= '0;
            rpt_valid_q  <= 1'b0;
            err_prot_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                rpt_layer_q  <= layer_q;
                rpt_cycles_q <= cyc_s[CNT_W-1:0];
                rpt_active_q <= act_s[CNT_W-1:0];
                rpt_mac_q    <= mac_s[CNT_W-1:0];
                rpt_stall_q  <= stl_s[CNT_W-1:0];
                rpt_flags_q  <= {trunc, sat_n};
            end
            if (closing) begin
                layer_q <= layer_q + LAYER_W'(1);
            end
            rpt_valid_q <= rpt_valid_d;
            err_prot_q  <= err_prot_q | (in_run && layer_start && !layer_done && !sim_done) |
                           (!in_run && layer_done);
            err_ovf_q   <= err_ovf_q | (closing && !accept);
        end
    end

    assign rpt_valid    = rpt_valid_q;
    assign rpt_layer    = rpt_layer_q;
    assign rpt_cycles   = rpt_cycles_q;
    assign rpt_active   = rpt_active_q;
    assign rpt_mac      = rpt_mac_q;
    assign rpt_stall    = rpt_stall_q;
    assign rpt_flags    = rpt_flags_q;
    assign rpt_util_pm  = (div_quot > QUOT_W'(PM_SCALE)) ? PM_W'(PM_SCALE) : div_quot[PM_W-1:0];
    assign err_protocol = err_prot_q;
    assign err_overflow = err_ovf_q;

endmodule
